// File: rtl/aes_pkg.sv
// Shared AES definitions: one-hot state codes for the key-schedule walkers,
// the round-constant table and the S-box used by both key expander directions.
package aes_pkg;

  // One-hot state code of the key-schedule controller.
  typedef logic [6:0] state_t;

  localparam state_t S_IDLE     = 7'b0000001;
  localparam state_t S_WAIT_ACK = 7'b0000010;
  localparam state_t S_W3       = 7'b0000100;
  localparam state_t S_W2       = 7'b0001000;
  localparam state_t S_W1       = 7'b0010000;
  localparam state_t S_G        = 7'b0100000;
  localparam state_t S_W0       = 7'b1000000;

  // Round constants; entry 0 is unused by the schedule and kept as zero.
  localparam logic [7:0] RCON [0:10] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Forward AES S-box, indexed by the input byte.
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Single S-box byte substitution.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // Round constant for round r; rounds outside 1..10 give zero.
  function automatic logic [7:0] rcon_lookup(input logic [3:0] r);
    return (r <= 4'd10) ? RCON[r] : 8'h00;
  endfunction

  // True when exactly one bit of the state code is set.
  function automatic logic state_is_onehot(input state_t s);
    return (s != '0) && ((s & (s - 7'd1)) == '0);
  endfunction

endpackage

// File: rtl/g_function_rc.sv
// Key-schedule g-function: SubWord(RotWord(x)) ^ {RCON[round], 24'h0}.
// The result is registered; done pulses the cycle after enable is sampled.
module g_function_rc (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [3:0]  round,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        done
);

  import aes_pkg::*;

  logic [31:0] rot_word;
  logic [31:0] sub_word;

  // Byte 0 of a word sits in bits [31:24], so the rotate moves it to the bottom.
  assign rot_word = {data_in[23:0], data_in[31:24]};
  assign sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                     sbox(rot_word[15:8]),  sbox(rot_word[7:0])};

  // Capture the transformed word whenever a request is sampled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out <= '0;
      done     <= 1'b0;
    end else begin
      done <= enable;
      if (enable) begin
        data_out <= sub_word ^ {rcon_lookup(round), 24'h000000};
      end
    end
  end

endmodule

// File: rtl/key_exp_inv_128.sv
// Inverse AES-128 key expansion. Loads the round-10 key and presents round
// keys 10 down to 0, each recovered from the next-higher round by XOR.
//
// Handshake: key_ready=1 means key_out/key_transform are valid and stay
// stable until the consumer raises key_ack; key_ack is only looked at while
// a key is being offered, and the cycle after it is sampled key_ready drops.
module key_exp_inv_128 (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         key_ack,
  input  logic [127:0] key,
  output logic         key_ready,
  output logic [3:0]   key_transform,
  output logic [127:0] key_out,
  output logic         o_state_error
);

  import aes_pkg::*;

  state_t           present_state;
  logic [3:0][31:0] kr;
  logic             enable_reg;

  logic             g_enable;
  logic [3:0]       g_round;
  logic [31:0]      g_in;
  logic [31:0]      g_out;
  logic             g_done;
  logic [31:0]      w0_next;

  // Any code that is not exactly one-hot is reported immediately.
  assign o_state_error = !state_is_onehot(present_state);

  // The g request is a single-cycle pulse: dropped as soon as the result returns.
  assign g_enable = (present_state == S_G) && !g_done && !o_state_error;
  assign g_round  = key_transform;
  assign g_in     = kr[3];
  assign w0_next  = kr[0] ^ g_out;

  g_function_rc u_g_function_rc (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (g_enable),
    .round    (g_round),
    .data_in  (g_in),
    .data_out (g_out),
    .done     (g_done)
  );

  // Controller and key-word registers. Words are undone in the order
  // w3, w2, w1 (each still needs its lower neighbour intact), then w0 via g
  // applied to the already-recovered previous-round w3.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      present_state <= S_IDLE;
      kr            <= '0;
      key_out       <= '0;
      key_transform <= 4'd0;
      key_ready     <= 1'b0;
      enable_reg    <= 1'b0;
    end else begin
      enable_reg <= enable;
      if (o_state_error) begin
        present_state <= S_IDLE;
        key_ready     <= 1'b0;
        key_transform <= 4'd0;
      end else begin
        case (present_state)
          S_IDLE: begin
            if (enable && !enable_reg) begin
              kr            <= key;
              key_out       <= key;
              key_transform <= 4'd10;
              key_ready     <= 1'b1;
              present_state <= S_WAIT_ACK;
            end else begin
              key_ready <= 1'b0;
            end
          end
          S_WAIT_ACK: begin
            if (key_ack) begin
              key_ready     <= 1'b0;
              present_state <= (key_transform == 4'd0) ? S_IDLE : S_W3;
            end
          end
          S_W3: begin
            kr[3]         <= kr[3] ^ kr[2];
            present_state <= S_W2;
          end
          S_W2: begin
            kr[2]         <= kr[2] ^ kr[1];
            present_state <= S_W1;
          end
          S_W1: begin
            kr[1]         <= kr[1] ^ kr[0];
            present_state <= S_G;
          end
          S_G: begin
            if (g_done) begin
              present_state <= S_W0;
            end
          end
          S_W0: begin
            kr[0]         <= w0_next;
            key_out       <= {kr[3], kr[2], kr[1], w0_next};
            key_transform <= (key_transform != 4'd0) ? (key_transform - 4'd1) : 4'd0;
            key_ready     <= 1'b1;
            present_state <= S_WAIT_ACK;
          end
          default: begin
            present_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_exp_inv_128.sv
// Bench for key_exp_inv_128: random keys checked against a word-level
// inverse key schedule with an S-box derived from GF(2^8) arithmetic.
module tb_key_exp_inv_128;

  import aes_pkg::*;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic         key_ack;
  logic [127:0] key;
  logic         key_ready;
  logic [3:0]   key_transform;
  logic [127:0] key_out;
  logic         o_state_error;

  always #5 clk = ~clk;

  key_exp_inv_128 dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .key_ack       (key_ack),
    .key           (key),
    .key_ready     (key_ready),
    .key_transform (key_transform),
    .key_out       (key_out),
    .o_state_error (o_state_error)
  );

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] FIPS_K10 = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;
  localparam logic [127:0] FIPS_K9  = 128'h575c006e_28d12941_19fadc21_ac7766f3;
  localparam logic [127:0] FIPS_K1  = 128'h2a6c7605_23a33939_88542cb1_a0fafe17;
  localparam logic [127:0] FIPS_K0  = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;

  // ---------------- reference model ----------------
  logic [127:0] exp_q[$];
  logic [7:0]   sbox_t [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box = affine transform of the multiplicative inverse.
  function automatic void build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [7:0] ref_rcon(input int r);
    logic [7:0] c = 8'h01;
    for (int i = 1; i < r; i++) c = xtime(c);
    return c;
  endfunction

  function automatic logic [31:0] ref_g(input logic [31:0] x, input int r);
    logic [31:0] t = {x[23:0], x[31:24]};
    return {sbox_t[t[31:24]] ^ ref_rcon(r), sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  // Recover the 44-word schedule from its last four words, queue rounds 10..0.
  function automatic void build_expected(input logic [127:0] k10);
    logic [31:0] w [44];
    logic [31:0] temp;
    for (int j = 0; j < 4; j++) w[40 + j] = k10[32*j +: 32];
    for (int i = 39; i >= 0; i--) begin
      temp = (i % 4 == 0) ? ref_g(w[i + 3], i / 4 + 1) : w[i + 3];
      w[i] = w[i + 4] ^ temp;
    end
    exp_q.delete();
    for (int r = 10; r >= 0; r--) exp_q.push_back({w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]});
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_key(input logic [127:0] k);
    @(negedge clk);
    key    = k;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (key_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic ack_once();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      enable  = 1'($urandom_range(0, 1));
      key_ack = 1'($urandom_range(0, 1));
      key     = rand_key();
    end
    checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", key_ready); end
    checks++; if (key_transform !== 4'd0) begin failures++; $display("FAIL reset_kt: got %0d want 0", key_transform); end
    checks++; if (key_out !== 128'h0) begin failures++; $display("FAIL reset_key_out: got %h want 0", key_out); end
    checks++; if (o_state_error !== 1'b0) begin failures++; $display("FAIL reset_state_error: got %b want 0", o_state_error); end
    enable  = 1'b0;
    key_ack = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fips();
    bit ok;
    logic [127:0] exp;
    build_expected(FIPS_K10);
    load_key(FIPS_K10);
    for (int r = 10; r >= 0; r--) begin
      wait_ready(ok);
      checks++; if (!ok) begin failures++; $display("FAIL fips_timeout: round %0d never ready", r); break; end
      exp = exp_q.pop_front();
      checks++; if (key_transform !== 4'(r)) begin failures++; $display("FAIL fips_kt: got %0d want %0d", key_transform, r); end
      checks++; if (key_out !== exp) begin failures++; $display("FAIL fips_model r%0d: got %h want %h", r, key_out, exp); end
      if (r == 9) begin checks++; if (key_out !== FIPS_K9) begin failures++; $display("FAIL fips_k9: got %h want %h", key_out, FIPS_K9); end end
      if (r == 1) begin checks++; if (key_out !== FIPS_K1) begin failures++; $display("FAIL fips_k1: got %h want %h", key_out, FIPS_K1); end end
      if (r == 0) begin checks++; if (key_out !== FIPS_K0) begin failures++; $display("FAIL fips_k0: got %h want %h", key_out, FIPS_K0); end end
      ack_once();
      checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL fips_ready_drop r%0d: got %b want 0", r, key_ready); end
    end
    checks++; if (dut.present_state !== S_IDLE) begin failures++; $display("FAIL fips_idle: got %b want %b", dut.present_state, S_IDLE); end
    @(negedge clk);
    checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL fips_idle_ready: got %b want 0", key_ready); end
  endtask

  task automatic test_ack_high();
    int last = -1;
    int seen = 0;
    logic [127:0] k = rand_key();
    build_expected(k);
    key_ack = 1'b1;
    load_key(k);
    for (int n = 0; n <= 71; n++) begin
      if (key_ready === 1'b1) begin
        if (seen > 10) begin
          checks++; failures++; $display("FAIL ackhigh_extra: key_ready at offset %0d after 11 rounds", n);
        end else begin
          checks++; if (key_transform !== 4'(10 - seen)) begin failures++; $display("FAIL ackhigh_kt: got %0d want %0d", key_transform, 10 - seen); end
          checks++; if (key_out !== exp_q[0]) begin failures++; $display("FAIL ackhigh_key: got %h want %h", key_out, exp_q[0]); end
          void'(exp_q.pop_front());
          if (seen > 0) begin
            checks++; if (n - last != 7) begin failures++; $display("FAIL ackhigh_gap: got %0d want 7", n - last); end
          end
          if (seen == 10) begin
            checks++; if (n != 70) begin failures++; $display("FAIL ackhigh_finish: got offset %0d want 70", n); end
          end
        end
        last = n;
        seen++;
      end
      @(negedge clk);
    end
    key_ack = 1'b0;
    checks++; if (seen != 11) begin failures++; $display("FAIL ackhigh_count: got %0d want 11", seen); end
    checks++; if (dut.present_state !== S_IDLE || key_ready !== 1'b0) begin failures++; $display("FAIL ackhigh_idle: state %b ready %b want %b 0", dut.present_state, key_ready, S_IDLE); end
  endtask

  task automatic test_ignored_inputs();
    bit ok;
    int w1_pulses = 0;
    int g_toggles = 0;
    logic [127:0] k = rand_key();
    build_expected(k);
    load_key(k);
    for (int r = 10; r >= 0; r--) begin
      wait_ready(ok);
      checks++; if (!ok) begin failures++; $display("FAIL ign_timeout: round %0d never ready", r); break; end
      checks++; if (key_transform !== 4'(r)) begin failures++; $display("FAIL ign_kt: got %0d want %0d", key_transform, r); end
      checks++; if (key_out !== exp_q[0]) begin failures++; $display("FAIL ign_key r%0d: got %h want %h", r, key_out, exp_q[0]); end
      void'(exp_q.pop_front());
      ack_once();
      for (int i = 0; i < 12 && r > 0; i++) begin
        if (key_ready === 1'b1) break;
        key_ack = (dut.present_state === S_W1);
        if (dut.present_state === S_W1) w1_pulses++;
        if (dut.present_state === S_G) begin enable = ~enable; g_toggles++; end
        else enable = 1'b0;
        @(negedge clk);
      end
      key_ack = 1'b0;
      enable  = 1'b0;
    end
    checks++; if (w1_pulses != 10 || g_toggles != 20) begin failures++; $display("FAIL ign_stimulus: w1 %0d g %0d want 10 20", w1_pulses, g_toggles); end
    @(negedge clk);
    checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL ign_no_restart: got %b want 0", key_ready); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit_g = 1'b0;
    logic [127:0] k1 = rand_key();
    logic [127:0] k2 = rand_key();
    load_key(k1);
    for (int r = 10; r >= 5; r--) begin
      wait_ready(ok);
      if (!ok) break;
      ack_once();
    end
    for (int i = 0; i < 12; i++) begin
      if (dut.present_state === S_G) begin hit_g = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!hit_g || key_transform !== 4'd5) begin failures++; $display("FAIL rmid_reach: hit %b kt %0d want 1 5", hit_g, key_transform); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (key_ready !== 1'b0 || key_transform !== 4'd0) begin failures++; $display("FAIL rmid_ctrl: ready %b kt %0d want 0 0", key_ready, key_transform); end
    checks++; if (key_out !== 128'h0) begin failures++; $display("FAIL rmid_key_out: got %h want 0", key_out); end
    checks++; if (dut.present_state !== S_IDLE) begin failures++; $display("FAIL rmid_state: got %b want %b", dut.present_state, S_IDLE); end
    // enable already high at reset release must count as a rising edge
    key     = k2;
    enable  = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    checks++; if (key_ready !== 1'b1 || key_transform !== 4'd10) begin failures++; $display("FAIL rmid_reload: ready %b kt %0d want 1 10", key_ready, key_transform); end
    checks++; if (key_out !== k2) begin failures++; $display("FAIL rmid_reload_key: got %h want %h", key_out, k2); end
    build_expected(k2);
    for (int r = 10; r >= 0; r--) begin
      wait_ready(ok);
      checks++; if (!ok) begin failures++; $display("FAIL rmid_timeout: round %0d", r); break; end
      checks++; if (key_out !== exp_q[0]) begin failures++; $display("FAIL rmid_seq r%0d: got %h want %h", r, key_out, exp_q[0]); end
      void'(exp_q.pop_front());
      ack_once();
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [127:0] held;
    for (int t = 0; t < 3; t++) begin
      logic [127:0] k = rand_key();
      build_expected(k);
      load_key(k);
      for (int r = 10; r >= 0; r--) begin
        wait_ready(ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout: key %0d round %0d", t, r); break; end
        checks++; if (key_transform !== 4'(r) || key_out !== exp_q[0]) begin failures++; $display("FAIL b2b_key: kt %0d %h want %0d %h", key_transform, key_out, r, exp_q[0]); end
        void'(exp_q.pop_front());
        held = key_out;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        checks++; if (key_ready !== 1'b1 || key_out !== held) begin failures++; $display("FAIL b2b_stable: ready %b %h want 1 %h", key_ready, key_out, held); end
        ack_once();
      end
    end
  endtask

  task automatic test_illegal_state();
    bit ok;
    load_key(rand_key());
    wait_ready(ok);
    checks++; if (!ok) begin failures++; $display("FAIL ill_setup: key never ready"); end
    force dut.present_state = 7'b0000011;
    #1;
    checks++; if (o_state_error !== 1'b1) begin failures++; $display("FAIL ill_flag: got %b want 1", o_state_error); end
    release dut.present_state;
    @(negedge clk);
    checks++; if (dut.present_state !== S_IDLE) begin failures++; $display("FAIL ill_recover: got %b want %b", dut.present_state, S_IDLE); end
    checks++; if (key_ready !== 1'b0 || key_transform !== 4'd0) begin failures++; $display("FAIL ill_clear: ready %b kt %0d want 0 0", key_ready, key_transform); end
    checks++; if (o_state_error !== 1'b0) begin failures++; $display("FAIL ill_flag_clear: got %b want 0", o_state_error); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    key_ack = 1'b0;
    key     = '0;
    build_sbox();
    test_reset();
    test_fips();
    test_ack_high();
    test_ignored_inputs();
    test_reset_mid();
    test_back_to_back();
    test_illegal_state();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
